// File: rtl/hilo_scoreboard.sv
// HI/LO scoreboard: counts in-flight pipeline writers per special register,
// tracks the mult/div unit, and raises the decode stall on hazards.
module hilo_scoreboard #(
    parameter int NREG     = 2,
    parameter int MAX_PEND = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            issue_valid,
    input  logic [NREG-1:0] issue_rd_mask,
    input  logic [NREG-1:0] issue_wr_mask,
    input  logic            issue_multicycle,
    output logic            stall,
    input  logic            wb_valid,
    input  logic [NREG-1:0] wb_mask,
    input  logic            md_done,
    input  logic            flush,
    output logic [NREG-1:0] pend_mask,
    output logic            md_busy,
    output logic            err
);

    localparam int CW = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_PEND);

    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] md_mask;
    logic [NREG-1:0] nz;
    logic [NREG-1:0] full;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic            raw;
    logic            waw;
    logic            strc;
    logic            cap;
    logic            accept;
    logic            wb_err;
    logic            md_err;

    always_comb begin
        nz   = '0;
        full = '0;
        for (int i = 0; i < NREG; i++) begin
            nz[i]   = cnt[i] != '0;
            full[i] = cnt[i] == CMAX;
        end
    end

    assign pend_mask = nz | md_mask;

    assign raw  = |(issue_rd_mask & pend_mask);
    assign waw  = |(issue_wr_mask & md_mask);
    assign strc = issue_multicycle & md_busy;
    assign cap  = ~issue_multicycle & |(issue_wr_mask & full);

    assign stall  = issue_valid & (raw | waw | strc | cap);
    assign accept = issue_valid & ~stall & ~flush;

    assign inc = (accept & ~issue_multicycle) ? issue_wr_mask : '0;
    // Retire on an empty counter is blocked so the counter never wraps.
    assign dec = wb_valid ? (wb_mask & nz) : '0;

    assign wb_err = wb_valid & ~flush & |(wb_mask & ~nz);
    assign md_err = md_done & ~md_busy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            md_busy <= 1'b0;
            md_mask <= '0;
            err     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (flush) begin
                    cnt[i] <= '0;
                end else if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (dec[i] && !inc[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
            // A started mult/div survives flush and always commits.
            if (accept && issue_multicycle) begin
                md_busy <= 1'b1;
                md_mask <= issue_wr_mask;
            end else if (md_done) begin
                md_busy <= 1'b0;
                md_mask <= '0;
            end
            if (wb_err || md_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hilo_scoreboard.sv
// Self-checking bench for hilo_scoreboard: directed plan plus random traffic
// compared every cycle against a behavioural model.
module tb_hilo_scoreboard;

    localparam int NREG     = 2;
    localparam int MAX_PEND = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            issue_valid;
    logic [NREG-1:0] issue_rd_mask;
    logic [NREG-1:0] issue_wr_mask;
    logic            issue_multicycle;
    logic            stall;
    logic            wb_valid;
    logic [NREG-1:0] wb_mask;
    logic            md_done;
    logic            flush;
    logic [NREG-1:0] pend_mask;
    logic            md_busy;
    logic            err;

    int ncmp = 0;
    int nbad = 0;

    // behavioural model state
    int              m_cnt [NREG];
    bit              m_busy;
    bit [NREG-1:0]   m_mask;
    bit              m_err;

    hilo_scoreboard #(.NREG(NREG), .MAX_PEND(MAX_PEND)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .issue_valid      (issue_valid),
        .issue_rd_mask    (issue_rd_mask),
        .issue_wr_mask    (issue_wr_mask),
        .issue_multicycle (issue_multicycle),
        .stall            (stall),
        .wb_valid         (wb_valid),
        .wb_mask          (wb_mask),
        .md_done          (md_done),
        .flush            (flush),
        .pend_mask        (pend_mask),
        .md_busy          (md_busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    function automatic bit [NREG-1:0] m_pend();
        bit [NREG-1:0] p;
        for (int i = 0; i < NREG; i++) p[i] = (m_cnt[i] != 0) || m_mask[i];
        return p;
    endfunction

    function automatic bit m_stall();
        bit hz;
        if (!issue_valid) return 1'b0;
        hz = (issue_rd_mask & m_pend()) != 0;
        hz |= (issue_wr_mask & m_mask) != 0;
        hz |= issue_multicycle && m_busy;
        for (int i = 0; i < NREG; i++)
            if (!issue_multicycle && issue_wr_mask[i] && m_cnt[i] == MAX_PEND)
                hz = 1'b1;
        return hz;
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
            m_busy = 0;
            m_mask = '0;
            m_err  = 0;
        end else begin
            acc = issue_valid && !m_stall() && !flush;
            if (md_done && !m_busy) m_err = 1;
            for (int i = 0; i < NREG; i++) begin
                if (flush) begin
                    m_cnt[i] = 0;
                end else begin
                    if (wb_valid && wb_mask[i]) begin
                        if (m_cnt[i] == 0) m_err = 1;
                        else m_cnt[i] = m_cnt[i] - 1;
                    end
                    if (acc && !issue_multicycle && issue_wr_mask[i])
                        m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (acc && issue_multicycle) begin
                m_busy = 1;
                m_mask = issue_wr_mask;
            end else if (md_done) begin
                m_busy = 0;
                m_mask = '0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            chk("model_stall", 32'(stall), 32'(m_stall()));
            chk("model_pend", 32'(pend_mask), 32'(m_pend()));
            chk("model_busy", 32'(md_busy), 32'(m_busy));
            chk("model_err", 32'(err), 32'(m_err));
        end
    end

    task automatic idle();
        issue_valid = 0; issue_rd_mask = '0; issue_wr_mask = '0;
        issue_multicycle = 0; wb_valid = 0; wb_mask = '0;
        md_done = 0; flush = 0;
    endtask

    task automatic iss(input bit [1:0] rd, input bit [1:0] wr, input bit mc);
        issue_valid = 1; issue_rd_mask = rd; issue_wr_mask = wr;
        issue_multicycle = mc;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 0;
        nxt();
        nxt();
        resetn = 1;
    endtask

    initial begin
        idle();
        resetn = 0;
        iss(2'b11, 2'b11, 1'b1);
        wb_valid = 1; wb_mask = 2'b11; md_done = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle();
        resetn = 1;
        at_neg();
        chk("rst_pend", 32'(pend_mask), 32'h0);
        chk("rst_busy", 32'(md_busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);

        // RAW on HI
        nxt(); iss(2'b00, 2'b10, 0); at_neg();
        chk("mthi_stall", 32'(stall), 32'h0);
        nxt(); iss(2'b10, 2'b00, 0); at_neg();
        chk("raw_pend", 32'(pend_mask), 32'h2);
        chk("raw_stall", 32'(stall), 32'h1);
        nxt(); iss(2'b10, 2'b00, 0); wb_valid = 1; wb_mask = 2'b10; at_neg();
        chk("raw_wb_same", 32'(stall), 32'h1);
        nxt(); iss(2'b10, 2'b00, 0); at_neg();
        chk("raw_release", 32'(stall), 32'h0);
        chk("raw_pend0", 32'(pend_mask), 32'h0);

        // mult/div
        nxt(); iss(2'b00, 2'b11, 1); at_neg();
        chk("mult_acc", 32'(stall), 32'h0);
        nxt(); iss(2'b01, 2'b00, 0); at_neg();
        chk("md_busy", 32'(md_busy), 32'h1);
        chk("mflo_stall", 32'(stall), 32'h1);
        nxt(); iss(2'b00, 2'b11, 1); at_neg();
        chk("div_stall", 32'(stall), 32'h1);
        nxt(); iss(2'b00, 2'b11, 1); md_done = 1; at_neg();
        chk("div_done_same", 32'(stall), 32'h1);
        nxt(); iss(2'b01, 2'b00, 0); at_neg();
        chk("mflo_free", 32'(stall), 32'h0);
        chk("md_idle", 32'(md_busy), 32'h0);

        // capacity on LO
        repeat (3) begin
            nxt(); iss(2'b00, 2'b01, 0); at_neg();
            chk("cap_fill", 32'(stall), 32'h0);
        end
        nxt(); iss(2'b00, 2'b01, 0); wb_valid = 1; wb_mask = 2'b01; at_neg();
        chk("cap_stall", 32'(stall), 32'h1);
        nxt(); iss(2'b00, 2'b01, 0); at_neg();
        chk("cap_accept", 32'(stall), 32'h0);
        repeat (3) begin
            nxt(); wb_valid = 1; wb_mask = 2'b01;
        end
        nxt(); at_neg();
        chk("cap_drained", 32'(pend_mask), 32'h0);
        chk("cap_err", 32'(err), 32'h0);

        // flush
        nxt(); iss(2'b00, 2'b10, 0);
        nxt(); iss(2'b00, 2'b10, 0);
        nxt(); iss(2'b00, 2'b11, 1);
        nxt(); iss(2'b00, 2'b10, 0); flush = 1; wb_valid = 1; wb_mask = 2'b01;
        nxt(); at_neg();
        chk("fl_pend", 32'(pend_mask), 32'h3);
        chk("fl_busy", 32'(md_busy), 32'h1);
        chk("fl_err", 32'(err), 32'h0);
        md_done = 1;
        nxt(); at_neg();
        chk("fl_cnt0", 32'(pend_mask), 32'h0);

        // errors
        nxt(); wb_valid = 1; wb_mask = 2'b01;
        nxt(); at_neg();
        chk("wb_err", 32'(err), 32'h1);
        nxt(); nxt(); at_neg();
        chk("err_sticky", 32'(err), 32'h1);
        do_reset(); at_neg();
        chk("err_clr", 32'(err), 32'h0);
        nxt(); md_done = 1;
        nxt(); at_neg();
        chk("md_err", 32'(err), 32'h1);
        do_reset();

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            bit [NREG-1:0] pm;
            nxt();
            if ($urandom_range(99) == 0) resetn = 0;
            else resetn = 1;
            for (int i = 0; i < NREG; i++) pm[i] = m_cnt[i] != 0;
            issue_valid      = $urandom_range(1);
            issue_rd_mask    = NREG'($urandom);
            issue_multicycle = $urandom_range(4) == 0;
            issue_wr_mask    = issue_multicycle ? '1 : NREG'($urandom);
            wb_valid         = $urandom_range(2) == 0;
            wb_mask          = ($urandom_range(19) == 0) ? NREG'($urandom)
                                                         : (pm & NREG'($urandom));
            md_done          = m_busy ? ($urandom_range(3) == 0)
                                      : ($urandom_range(49) == 0);
            flush            = $urandom_range(32) == 0;
            if (m_err && $urandom_range(9) == 0) resetn = 0;
        end
        nxt();
        resetn = 1;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
